spi_frame_master: RTL and testbench

- SPI master that streams one full display frame to the display controller's SPI slave input. This is the host/test-side counterpart of the frame receiver.
- Fetches 16-bit pixels from a synchronous frame source and frames each transfer with ss (sot at ss fall, eot at ss rise).
- Shifts each pixel as 2 bytes, MSB first, SPI mode 0.
- Used in the host-side bridge and as the stimulus generator in display-controller system benches.

---
 rtl/spi_frame_master_if.sv | 41 ++++
 rtl/spi_frame_master.sv | 177 +++++++++++++++++
 tb/tb_spi_frame_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_master_if.sv
// rtl/spi_frame_master_if.sv - frame master control, pixel fetch and SPI pin bundle
interface spi_frame_master_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic [15:0]       pix_data;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;

    modport master (
        input  start,
        output busy,
        output done,
        output pix_req,
        output pix_addr,
        input  pix_data,
        output sclk,
        output ss,
        output mosi,
        input  miso
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  pix_req,
        input  pix_addr,
        output pix_data,
        input  sclk,
        input  ss,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI mode-0 master streaming one frame of 16-bit pixels
module spi_frame_master #(
    parameter int PIXELS   = 256,
    parameter int ADDR_W   = 8,
    parameter int CLKDIV   = 4,
    parameter int SS_LEAD  = 4,
    parameter int SS_TRAIL = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    spi_frame_master_if.master   bus
);
    localparam int DIV_W   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int GAP_MAX = (SS_LEAD > SS_TRAIL) ? SS_LEAD : SS_TRAIL;
    localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLKDIV - 1);
    localparam logic [GAP_W-1:0]  LEAD_LAST  = GAP_W'(SS_LEAD - 1);
    localparam logic [GAP_W-1:0]  TRAIL_LAST = GAP_W'(SS_TRAIL - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(PIXELS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_TRAIL = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q,    state_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic [3:0]        bit_q,      bit_d;
    logic [ADDR_W-1:0] pix_cnt_q,  pix_cnt_d;
    logic [15:0]       shreg_q,    shreg_d;
    logic              ss_q,       ss_d;
    logic              sclk_q,     sclk_d;
    logic              mosi_q,     mosi_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              pix_req_q,  pix_req_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

    // No readback: the slave's output is never looked at.
    logic miso_unused;
    assign miso_unused = bus.miso;

    // Next-state logic; every SPI pin change is decided here and registered below.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        div_d      = div_q;
        bit_d      = bit_q;
        pix_cnt_d  = pix_cnt_q;
        shreg_d    = shreg_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pix_req_d  = 1'b0;
        pix_addr_d = pix_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LEAD;
                    ss_d      = 1'b0;
                    busy_d    = 1'b1;
                    pix_cnt_d = '0;
                    gap_d     = '0;
                end
            end
            S_LEAD: begin
                if (gap_q == LEAD_LAST) begin
                    state_d    = S_FETCH;
                    pix_req_d  = 1'b1;
                    pix_addr_d = pix_cnt_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Source answers one cycle after the strobe, i.e. now.
                shreg_d = bus.pix_data;
                mosi_d  = bus.pix_data[15];
                bit_d   = 4'd0;
                div_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: present the next bit well before the next rise.
                        shreg_d = {shreg_q[14:0], 1'b0};
                        mosi_d  = shreg_q[14];
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            if (pix_cnt_q == PIX_LAST) begin
                                state_d = S_TRAIL;
                                gap_d   = '0;
                            end else begin
                                pix_cnt_d  = pix_cnt_q + 1'b1;
                                pix_addr_d = pix_cnt_q + 1'b1;
                                pix_req_d  = 1'b1;
                                state_d    = S_FETCH;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_TRAIL: begin
                if (gap_q == TRAIL_LAST) begin
                    state_d = S_DONE;
                    ss_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops ss at once so the slave sees end of transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            div_q      <= '0;
            bit_q      <= 4'd0;
            pix_cnt_q  <= '0;
            shreg_q    <= 16'h0000;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pix_req_q  <= 1'b0;
            pix_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            pix_cnt_q  <= pix_cnt_d;
            shreg_q    <= shreg_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pix_req_q  <= pix_req_d;
            pix_addr_q <= pix_addr_d;
        end
    end

    assign bus.ss       = ss_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pix_req  = pix_req_q;
    assign bus.pix_addr = pix_addr_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed bench for spi_frame_master with an SPI slave capture model
module tb_spi_frame_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_frame_master_if #(.ADDR_W(1)) ifa ();
    spi_frame_master_if #(.ADDR_W(2)) ifb ();

    spi_frame_master #(.PIXELS(2), .ADDR_W(1), .CLKDIV(1), .SS_LEAD(2), .SS_TRAIL(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa.master));
    spi_frame_master #(.PIXELS(4), .ADDR_W(2), .CLKDIV(3), .SS_LEAD(3), .SS_TRAIL(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb.master));

    assign ifa.miso = 1'b0;
    assign ifb.miso = 1'b0;

    logic [15:0] src_a [2] = '{16'hA55A, 16'h0FF0};
    logic [15:0] src_b [4] = '{16'h1234, 16'h8001, 16'hFEDC, 16'h0F5A};
    logic [7:0]  exp_a [4] = '{8'hA5, 8'h5A, 8'h0F, 8'hF0};
    logic [7:0]  exp_b [8] = '{8'h12, 8'h34, 8'h80, 8'h01, 8'hFE, 8'hDC, 8'h0F, 8'h5A};

    // Synchronous frame source: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (ifa.pix_req) ifa.pix_data <= src_a[ifa.pix_addr];
        if (ifb.pix_req) ifb.pix_data <= src_b[ifb.pix_addr];
    end

    logic [1:0] m_sclk, m_ss, m_mosi, m_done, m_req, m_busy;
    logic [7:0] m_addr [2];
    assign m_sclk    = {ifb.sclk, ifa.sclk};
    assign m_ss      = {ifb.ss, ifa.ss};
    assign m_mosi    = {ifb.mosi, ifa.mosi};
    assign m_done    = {ifb.done, ifa.done};
    assign m_req     = {ifb.pix_req, ifa.pix_req};
    assign m_busy    = {ifb.busy, ifa.busy};
    assign m_addr[0] = {7'b0, ifa.pix_addr};
    assign m_addr[1] = {6'b0, ifb.pix_addr};

    logic       clr = 1'b0;
    int         ss_low [2], done_cnt [2], req_cnt [2], rises [2], nbits [2], nbytes [2];
    logic [7:0] first_addr [2];
    logic [7:0] cur [2];
    logic [7:0] rx [2][16];
    logic [1:0] p_sclk = 2'b00;
    logic [1:0] p_mosi = 2'b00;
    int         hi_run = 0, lo_run = 0, since = 0;
    int         hi_bad = 0, lo_bad = 0, mosi_bad = 0;

    // Slave model: captures mosi on sclk rises while ss is low; also times dut_b's sclk phases.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                ss_low[i] = 0; done_cnt[i] = 0; req_cnt[i] = 0; rises[i] = 0;
                nbits[i] = 0; nbytes[i] = 0; first_addr[i] = 8'hFF;
            end
            hi_bad = 0; lo_bad = 0; mosi_bad = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_done[i]) done_cnt[i]++;
            if (m_req[i]) begin
                if (req_cnt[i] == 0) first_addr[i] = m_addr[i];
                req_cnt[i]++;
            end
            if (!m_ss[i]) begin
                ss_low[i]++;
                if (m_sclk[i] && !p_sclk[i]) begin
                    cur[i] = {cur[i][6:0], m_mosi[i]};
                    nbits[i]++;
                    if (nbits[i] == 8) begin
                        if (nbytes[i] < 16) rx[i][nbytes[i]] = cur[i];
                        nbytes[i]++;
                        nbits[i] = 0;
                    end
                    if (i == 1) begin
                        if ((rises[i] % 16) != 0 && lo_run != 3) lo_bad++;
                        if (since < 3 || m_mosi[1] !== p_mosi[1]) mosi_bad++;
                    end
                    rises[i]++;
                end
            end else begin
                nbits[i] = 0;
            end
        end
        if (!m_ss[1]) begin
            if (m_sclk[1]) begin
                hi_run = p_sclk[1] ? hi_run + 1 : 1;
                if (p_sclk[1] && m_mosi[1] !== p_mosi[1]) mosi_bad++;
            end else if (p_sclk[1]) begin
                if (hi_run != 3) hi_bad++;
                lo_run = 1;
            end else begin
                lo_run++;
            end
        end
        since  = (m_mosi[1] !== p_mosi[1]) ? 1 : since + 1;
        p_sclk = m_sclk;
        p_mosi = m_mosi;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input int limit, input string tag);
        int n = 0;
        while (m_done[idx] !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk(tag, {31'b0, m_done[idx]}, 32'd1);
    endtask

    task automatic wait_rises(input int idx, input int target, input int limit, input string tag);
        int n = 0;
        while (rises[idx] < target && n < limit) begin
            step();
            n++;
        end
        chk(tag, (rises[idx] >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_frame_b(input string tag);
        chk({tag, "_req"}, req_cnt[1], 32'd4);
        chk({tag, "_done"}, done_cnt[1], 32'd1);
        chk({tag, "_sslow"}, ss_low[1], 32'd397);
        chk({tag, "_rises"}, rises[1], 32'd64);
        chk({tag, "_nbytes"}, nbytes[1], 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_byte%0d", tag, k), {24'b0, rx[1][k]}, {24'b0, exp_b[k]});
        chk({tag, "_ss_at_done"}, {31'b0, ifb.ss}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) step();
        chk("rst_a_ss", {31'b0, ifa.ss}, 32'd1);
        chk("rst_a_sclk", {31'b0, ifa.sclk}, 32'd0);
        chk("rst_a_mosi", {31'b0, ifa.mosi}, 32'd0);
        chk("rst_a_busy", {31'b0, ifa.busy}, 32'd0);
        chk("rst_a_done", {31'b0, ifa.done}, 32'd0);
        chk("rst_a_req", {31'b0, ifa.pix_req}, 32'd0);
        chk("rst_b_ss", {31'b0, ifb.ss}, 32'd1);
        chk("rst_b_sclk", {31'b0, ifb.sclk}, 32'd0);
        chk("rst_b_busy", {31'b0, ifb.busy}, 32'd0);
        chk("rst_b_addr", {30'b0, ifb.pix_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_a_ss", {31'b0, ifa.ss}, 32'd1);
        chk("idle_a_busy", {31'b0, ifa.busy}, 32'd0);
        chk("idle_b_sclk", {31'b0, ifb.sclk}, 32'd0);

        // Frame on dut_a: two pixels, CLKDIV=1.
        clr = 1'b1; ifa.start = 1'b1;
        step();
        clr = 1'b0; ifa.start = 1'b0;
        chk("a_busy_after_start", {31'b0, ifa.busy}, 32'd1);
        chk("a_ss_after_start", {31'b0, ifa.ss}, 32'd0);
        wait_done(0, 200, "a_done_seen");
        chk("a_ss_at_done", {31'b0, ifa.ss}, 32'd1);
        chk("a_busy_at_done", {31'b0, ifa.busy}, 32'd1);
        chk("a_sslow", ss_low[0], 32'd72);
        chk("a_req", req_cnt[0], 32'd2);
        chk("a_nbytes", nbytes[0], 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("a_byte%0d", k), {24'b0, rx[0][k]}, {24'b0, exp_a[k]});
        step();
        chk("a_done_one_cycle", {31'b0, ifa.done}, 32'd0);
        chk("a_busy_after_done", {31'b0, ifa.busy}, 32'd0);
        chk("a_done_cnt", done_cnt[0], 32'd1);

        // Frame on dut_b with a stray start mid-SHIFT.
        clr = 1'b1; ifb.start = 1'b1;
        step();
        clr = 1'b0; ifb.start = 1'b0;
        wait_rises(1, 5, 300, "b1_reach_shift");
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        chk("b1_busy_mid", {31'b0, ifb.busy}, 32'd1);
        wait_done(1, 1000, "b1_done_seen");
        chk_frame_b("b1");
        chk("b1_hi_phase", hi_bad, 32'd0);
        chk("b1_lo_phase", lo_bad, 32'd0);
        chk("b1_mosi_timing", mosi_bad, 32'd0);

        // start during DONE is ignored; start held into the following IDLE cycle is taken.
        ifb.start = 1'b1;
        step();
        chk("b_done_start_ignored", {31'b0, ifb.busy}, 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0; ifb.start = 1'b0;
        chk("b2_busy", {31'b0, ifb.busy}, 32'd1);
        chk("b2_ss", {31'b0, ifb.ss}, 32'd0);
        wait_done(1, 1000, "b2_done_seen");
        chk_frame_b("b2");
        chk("b2_mosi_timing", mosi_bad, 32'd0);
        step();

        // Reset in pixel 1, bit 7, then a full frame from address 0.
        clr = 1'b1; ifb.start = 1'b1;
        step();
        clr = 1'b0; ifb.start = 1'b0;
        wait_rises(1, 24, 1000, "b3_reach_bit7");
        chk("b3_ss_midframe", {31'b0, ifb.ss}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("b3_rst_ss", {31'b0, ifb.ss}, 32'd1);
        chk("b3_rst_sclk", {31'b0, ifb.sclk}, 32'd0);
        chk("b3_rst_busy", {31'b0, m_busy[1]}, 32'd0);
        chk("b3_rst_mosi", {31'b0, ifb.mosi}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("b3_idle_after_rst", {31'b0, ifb.busy}, 32'd0);
        clr = 1'b1; ifb.start = 1'b1;
        step();
        clr = 1'b0; ifb.start = 1'b0;
        wait_done(1, 1000, "b4_done_seen");
        chk("b4_first_addr", {24'b0, first_addr[1]}, 32'd0);
        chk_frame_b("b4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
